// File: rtl/alu_md_pkg.sv
// Shared opcodes, FSM state encoding and operand-signedness helpers for alu_md.
package alu_md_pkg;

    localparam logic [4:0] OP_ADD    = 5'b00001;
    localparam logic [4:0] OP_SUB    = 5'b00010;
    localparam logic [4:0] OP_SLT    = 5'b00011;
    localparam logic [4:0] OP_SLTU   = 5'b01011;
    localparam logic [4:0] OP_AND    = 5'b00100;
    localparam logic [4:0] OP_OR     = 5'b00101;
    localparam logic [4:0] OP_XOR    = 5'b00110;
    localparam logic [4:0] OP_SLL    = 5'b00111;
    localparam logic [4:0] OP_SRL    = 5'b01000;
    localparam logic [4:0] OP_SRA    = 5'b01001;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIXUP
    } state_t;

    // Multiply/divide opcodes all live in the 10xxx block; bit 2 selects divide.
    function automatic logic is_muldiv(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

    // Whether operand A (operand_b=0) or B (operand_b=1) is treated as signed
    // for a multiply/divide opcode. MUL takes the signed path; its low half is
    // the same either way.
    function automatic logic is_signed(input logic [4:0] op, input logic operand_b);
        if (op[2]) begin
            return !op[0];
        end else if (operand_b) begin
            return !op[1];
        end else begin
            return op[1:0] != 2'b11;
        end
    endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide
// on operand magnitudes, with the RISC-V sign correction applied on the result.
module alu_md_iter
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            start,
    input  logic            run,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] work_q, work_d;
    logic [XLEN-1:0]   mag_q, mag_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              rem_neg_q, rem_neg_d;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo, rem;

    assign a_neg = is_signed({2'b10, op}, 1'b0) && a[XLEN-1];
    assign b_neg = is_signed({2'b10, op}, 1'b1) && b[XLEN-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    assign mul_sum   = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, mag_q} : '0);
    assign div_shift = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, mag_q};
    assign div_diff  = div_shift - {1'b0, mag_q};

    assign last = (cnt_q == '0);

    // Load magnitudes on start, then advance one multiply or divide step per run cycle.
    always_comb begin
        cnt_d     = cnt_q;
        work_d    = work_q;
        mag_d     = mag_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        if (start) begin
            cnt_d     = CNT_W'(XLEN - 1);
            op_d      = op;
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            if (op[2]) begin
                work_d = {{XLEN{1'b0}}, mag_a};
                mag_d  = mag_b;
            end else begin
                work_d = {{XLEN{1'b0}}, mag_b};
                mag_d  = mag_a;
            end
        end else if (run) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (op_q[2]) begin
                work_d = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                          work_q[XLEN-2:0], div_ge};
            end else begin
                work_d = {mul_sum, work_q[XLEN-1:1]};
            end
        end
    end

    // Sign-correct the finished product, quotient or remainder.
    always_comb begin
        prod_signed = neg_q ? -work_q : work_q;
        quo         = work_q[XLEN-1:0];
        rem         = work_q[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            if (op_q[1]) begin
                result = rem_neg_q ? -rem : rem;
            end else begin
                result = neg_q ? -quo : quo;
            end
        end else if (op_q[1:0] == 2'b00) begin
            result = prod_signed[XLEN-1:0];
        end else begin
            result = prod_signed[2*XLEN-1:XLEN];
        end
    end

    // Datapath registers; everything freezes while held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            work_q    <= '0;
            mag_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (!hold) begin
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            mag_q     <= mag_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

endmodule

// File: rtl/alu_md.sv
// Execute-stage ALU: single-cycle RV32I ops plus iterative RV32M multiply/divide,
// with valid/ready handshake, registered result and flags.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            CK_REF,
    input  logic            RST,
    input  logic            HALT,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [4:0]      OP_VAL,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic [XLEN-1:0] OUT,
    output logic            OUT_VALID,
    output logic            CARRY_FLAG,
    output logic            ZERO_FLAG,
    output logic            OVERFLOW_FLAG,
    output logic            NEG_FLAG,
    output logic            OP_ERR
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic [XLEN-1:0] out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic            carry_q, carry_d;
    logic            zero_q, zero_d;
    logic            ovf_q, ovf_d;
    logic            neg_q, neg_d;
    logic            err_q, err_d;

    logic              ready_int, accept;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN:0]     add_sum, sub_dif;
    logic [XLEN-1:0]   sra_res;
    logic [XLEN-1:0]   sc_res;
    logic              sc_carry, sc_ovf, sc_err, sc_special;
    logic              iter_start, iter_run, iter_last;
    logic [XLEN-1:0]   iter_result;
    logic              load;
    logic [XLEN-1:0]   load_res;
    logic              load_carry, load_ovf, load_err;

    assign ready_int = (state_q == ST_IDLE) && !HALT;
    assign IN_READY  = ready_int && !RST;
    assign accept    = IN_VALID && ready_int && !FLUSH;

    assign shamt   = B[SHAMT_W-1:0];
    assign add_sum = {1'b0, A} + {1'b0, B};
    assign sub_dif = {1'b0, A} + {1'b0, ~B} + {{XLEN{1'b0}}, 1'b1};
    assign sra_res = $unsigned($signed(A) >>> shamt);

    // Single-cycle result, including the divide special cases that bypass iteration.
    always_comb begin
        sc_res     = '0;
        sc_carry   = 1'b0;
        sc_ovf     = 1'b0;
        sc_err     = 1'b0;
        sc_special = 1'b0;
        case (OP_VAL)
            OP_ADD: begin
                sc_res   = add_sum[XLEN-1:0];
                sc_carry = add_sum[XLEN];
                sc_ovf   = (A[XLEN-1] == B[XLEN-1]) && (add_sum[XLEN-1] != A[XLEN-1]);
            end
            OP_SUB: begin
                sc_res   = sub_dif[XLEN-1:0];
                sc_carry = sub_dif[XLEN];
                sc_ovf   = (A[XLEN-1] != B[XLEN-1]) && (sub_dif[XLEN-1] != A[XLEN-1]);
            end
            OP_SLT:  sc_res = {{(XLEN-1){1'b0}}, $signed(A) < $signed(B)};
            OP_SLTU: sc_res = {{(XLEN-1){1'b0}}, A < B};
            OP_AND:  sc_res = A & B;
            OP_OR:   sc_res = A | B;
            OP_XOR:  sc_res = A ^ B;
            OP_SLL:  sc_res = A << shamt;
            OP_SRL:  sc_res = A >> shamt;
            OP_SRA:  sc_res = sra_res;
            default: begin
                if (is_muldiv(OP_VAL) && OP_VAL[2]) begin
                    if (B == '0) begin
                        sc_special = 1'b1;
                        sc_res     = OP_VAL[1] ? A : '1;
                    end else if (!OP_VAL[0] && (A == INT_MIN) && (B == '1)) begin
                        sc_special = 1'b1;
                        sc_res     = OP_VAL[1] ? '0 : A;
                    end
                end else if (!is_muldiv(OP_VAL)) begin
                    sc_err = 1'b1;
                end
            end
        endcase
    end

    // Control FSM next state and result/flag loading.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        carry_d     = carry_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        neg_d       = neg_q;
        err_d       = err_q;
        iter_start  = 1'b0;
        load        = 1'b0;
        load_res    = '0;
        load_carry  = 1'b0;
        load_ovf    = 1'b0;
        load_err    = 1'b0;
        if (FLUSH) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_muldiv(OP_VAL) && !sc_special) begin
                            iter_start = 1'b1;
                            state_d    = OP_VAL[2] ? ST_DIV : ST_MUL;
                        end else begin
                            load       = 1'b1;
                            load_res   = sc_res;
                            load_carry = sc_carry;
                            load_ovf   = sc_ovf;
                            load_err   = sc_err;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (iter_last) begin
                        state_d = ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    load     = 1'b1;
                    load_res = iter_result;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (load) begin
            out_d       = load_res;
            out_valid_d = 1'b1;
            carry_d     = load_carry;
            ovf_d       = load_ovf;
            err_d       = load_err;
            zero_d      = (load_res == '0);
            neg_d       = load_res[XLEN-1];
        end
    end

    assign iter_run = ((state_q == ST_MUL) || (state_q == ST_DIV)) && !FLUSH;

    alu_md_iter #(.XLEN(XLEN)) u_iter (
        .clk    (CK_REF),
        .rst    (RST),
        .hold   (HALT),
        .start  (iter_start),
        .run    (iter_run),
        .op     (OP_VAL[2:0]),
        .a      (A),
        .b      (B),
        .last   (iter_last),
        .result (iter_result)
    );

    // State, result and flag registers; HALT freezes them all.
    always_ff @(posedge CK_REF or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
        end else if (!HALT) begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
        end
    end

    assign OUT           = out_q;
    assign OUT_VALID     = out_valid_q && !HALT;
    assign CARRY_FLAG    = carry_q;
    assign ZERO_FLAG     = zero_q;
    assign OVERFLOW_FLAG = ovf_q;
    assign NEG_FLAG      = neg_q;
    assign OP_ERR        = err_q;

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: table-driven single-cycle and multiply/divide
// vectors plus hand-written HALT, FLUSH and reset sequences.
module tb_alu_md;
    import alu_md_pkg::*;

   localparam int XLEN = 32;

   logic            CK_REF = 1'b0;
   logic            RST;
   logic            HALT;
   logic            FLUSH;
   logic            IN_VALID;
   logic            IN_READY;
   logic [4:0]      OP_VAL;
   logic [XLEN-1:0] A;
   logic [XLEN-1:0] B;
   logic [XLEN-1:0] OUT;
   logic            OUT_VALID;
   logic            CARRY_FLAG;
   logic            ZERO_FLAG;
   logic            OVERFLOW_FLAG;
   logic            NEG_FLAG;
   logic            OP_ERR;

   logic [31:0] flagWord;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [4:0]  flags;
   } vec_t;

   vec_t scTable[22];
   vec_t mdTable[14];

   alu_md #(.XLEN(XLEN)) dut (
      .CK_REF        (CK_REF),
      .RST           (RST),
      .HALT          (HALT),
      .FLUSH         (FLUSH),
      .IN_VALID      (IN_VALID),
      .IN_READY      (IN_READY),
      .OP_VAL        (OP_VAL),
      .A             (A),
      .B             (B),
      .OUT           (OUT),
      .OUT_VALID     (OUT_VALID),
      .CARRY_FLAG    (CARRY_FLAG),
      .ZERO_FLAG     (ZERO_FLAG),
      .OVERFLOW_FLAG (OVERFLOW_FLAG),
      .NEG_FLAG      (NEG_FLAG),
      .OP_ERR        (OP_ERR)
   );

   // Free-running clock, 10 time units per period.
   always #5 CK_REF = ~CK_REF;

   // Flags packed as {carry, zero, overflow, neg, op_err} for compact comparison.
   assign flagWord = {27'd0, CARRY_FLAG, ZERO_FLAG, OVERFLOW_FLAG, NEG_FLAG, OP_ERR};

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one op at a falling edge and advance to the next falling edge.
   task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      OP_VAL   = op;
      A        = a;
      B        = b;
      IN_VALID = 1'b1;
      @(negedge CK_REF);
   endtask

   task automatic issueOp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      applyStimulus(op, a, b);
      IN_VALID = 1'b0;
   endtask

   // Count cycles from the current one (cycle 1) until OUT_VALID, with a bound.
   task automatic waitValid(output int lat, output int busy);
      lat  = 1;
      busy = 0;
      while (!OUT_VALID && lat < 100) begin
         if (!IN_READY) busy++;
         @(negedge CK_REF);
         lat++;
      end
   endtask

   initial begin
      int lat;
      int busy;
      int pulses;

      RST      = 1'b1;
      HALT     = 1'b0;
      FLUSH    = 1'b0;
      IN_VALID = 1'b0;
      OP_VAL   = '0;
      A        = '0;
      B        = '0;

      scTable[0]  = '{OP_ADD,    32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b11000};
      scTable[1]  = '{OP_ADD,    32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b00110};
      scTable[2]  = '{OP_SRA,    32'h80000000, 32'h00000024, 32'hF8000000, 5'b00010};
      scTable[3]  = '{OP_SUB,    32'h00000005, 32'h00000003, 32'h00000002, 5'b10000};
      scTable[4]  = '{OP_SUB,    32'h00000003, 32'h00000005, 32'hFFFFFFFE, 5'b00010};
      scTable[5]  = '{OP_SUB,    32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b10100};
      scTable[6]  = '{OP_SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b00000};
      scTable[7]  = '{OP_SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b01000};
      scTable[8]  = '{OP_AND,    32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b00010};
      scTable[9]  = '{OP_OR,     32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 5'b00000};
      scTable[10] = '{OP_XOR,    32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 5'b00000};
      scTable[11] = '{OP_SLL,    32'h00000001, 32'h00000021, 32'h00000002, 5'b00000};
      scTable[12] = '{OP_SRL,    32'h80000000, 32'h0000001F, 32'h00000001, 5'b00000};
      scTable[13] = '{5'b11111,  32'h00000005, 32'h00000006, 32'h00000000, 5'b01001};
      scTable[14] = '{5'b00000,  32'h00000005, 32'h00000006, 32'h00000000, 5'b01001};
      scTable[15] = '{OP_DIVU,   32'h00001234, 32'h00000000, 32'hFFFFFFFF, 5'b00010};
      scTable[16] = '{OP_REM,    32'h00001234, 32'h00000000, 32'h00001234, 5'b00000};
      scTable[17] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5'b00010};
      scTable[18] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 5'b01000};
      scTable[19] = '{OP_SUB,    32'h00000000, 32'h00000000, 32'h00000000, 5'b11000};
      scTable[20] = '{OP_SLT,    32'h80000000, 32'h7FFFFFFF, 32'h00000001, 5'b00000};
      scTable[21] = '{OP_SRA,    32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 5'b00000};

      mdTable[0]  = '{OP_MULH,   32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 5'b00010};
      mdTable[1]  = '{OP_MUL,    32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 5'b00010};
      mdTable[2]  = '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 5'b00010};
      mdTable[3]  = '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 5'b00010};
      mdTable[4]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'b00010};
      mdTable[5]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00010};
      mdTable[6]  = '{OP_DIVU,   32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 5'b00000};
      mdTable[7]  = '{OP_REMU,   32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 5'b00000};
      mdTable[8]  = '{OP_DIV,    32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 5'b00010};
      mdTable[9]  = '{OP_REM,    32'h00000064, 32'hFFFFFFF9, 32'h00000002, 5'b00000};
      mdTable[10] = '{OP_MUL,    32'h00010000, 32'h00010000, 32'h00000000, 5'b01000};
      mdTable[11] = '{OP_MULHU,  32'h00010000, 32'h00010000, 32'h00000001, 5'b00000};
      mdTable[12] = '{OP_REMU,   32'h00000005, 32'h00000007, 32'h00000005, 5'b00000};
      mdTable[13] = '{OP_MULHSU, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 5'b00010};

      repeat (2) @(negedge CK_REF);
      checkOutput("reset OUT", OUT, 32'h0);
      checkOutput("reset flags", flagWord, 32'h0);
      checkOutput("reset OUT_VALID", {31'd0, OUT_VALID}, 32'h0);
      RST = 1'b0;
      @(negedge CK_REF);
      checkOutput("post-reset IN_READY", {31'd0, IN_READY}, 32'h1);

      for (int i = 0; i < 22; i++) begin
         applyStimulus(scTable[i].op, scTable[i].a, scTable[i].b);
         checkOutput($sformatf("sc%0d OUT", i), OUT, scTable[i].res);
         checkOutput($sformatf("sc%0d flags", i), flagWord, {27'd0, scTable[i].flags});
         checkOutput($sformatf("sc%0d OUT_VALID", i), {31'd0, OUT_VALID}, 32'h1);
         checkOutput($sformatf("sc%0d IN_READY", i), {31'd0, IN_READY}, 32'h1);
      end
      IN_VALID = 1'b0;
      @(negedge CK_REF);
      checkOutput("sc burst end OUT_VALID", {31'd0, OUT_VALID}, 32'h0);

      for (int i = 0; i < 14; i++) begin
         issueOp(mdTable[i].op, mdTable[i].a, mdTable[i].b);
         waitValid(lat, busy);
         checkOutput($sformatf("md%0d latency", i), lat, 32'd34);
         checkOutput($sformatf("md%0d busy cycles", i), busy, 32'd33);
         checkOutput($sformatf("md%0d OUT", i), OUT, mdTable[i].res);
         checkOutput($sformatf("md%0d flags", i), flagWord, {27'd0, mdTable[i].flags});
         @(negedge CK_REF);
         checkOutput($sformatf("md%0d pulse end", i), {31'd0, OUT_VALID}, 32'h0);
      end

      // HALT for 5 cycles around iteration 10 of a DIVU delays the result by 5.
      issueOp(OP_DIVU, 32'hFFFFFFFF, 32'h00000010);
      repeat (9) @(negedge CK_REF);
      HALT = 1'b1;
      repeat (5) @(negedge CK_REF);
      HALT = 1'b0;
      waitValid(lat, busy);
      checkOutput("halt latency", 14 + lat, 32'd39);
      checkOutput("halt OUT", OUT, 32'h0FFFFFFF);
      @(negedge CK_REF);
      checkOutput("halt pulse end", {31'd0, OUT_VALID}, 32'h0);

      // FLUSH mid-MUL: no result, ready again next cycle, OUT untouched.
      issueOp(OP_MUL, 32'h3, 32'h5);
      repeat (4) @(negedge CK_REF);
      FLUSH = 1'b1;
      @(negedge CK_REF);
      FLUSH = 1'b0;
      checkOutput("flush IN_READY", {31'd0, IN_READY}, 32'h1);
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         if (OUT_VALID) pulses++;
         @(negedge CK_REF);
      end
      checkOutput("flush no OUT_VALID", pulses, 32'd0);
      checkOutput("flush OUT kept", OUT, 32'h0FFFFFFF);

      // Asynchronous reset mid-MUL clears outputs before the next clock edge.
      issueOp(OP_MUL, 32'h3, 32'h5);
      repeat (3) @(negedge CK_REF);
      #2 RST = 1'b1;
      #1;
      checkOutput("async rst OUT", OUT, 32'h0);
      checkOutput("async rst flags", flagWord, 32'h0);
      checkOutput("async rst OUT_VALID", {31'd0, OUT_VALID}, 32'h0);
      @(negedge CK_REF);
      RST = 1'b0;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         if (OUT_VALID) pulses++;
         @(negedge CK_REF);
      end
      checkOutput("rst no OUT_VALID", pulses, 32'd0);
      checkOutput("rst IN_READY", {31'd0, IN_READY}, 32'h1);
      checkOutput("rst OUT held 0", OUT, 32'h0);

      issueOp(OP_ADD, 32'h2, 32'h3);
      checkOutput("final ADD OUT", OUT, 32'h5);
      checkOutput("final ADD OUT_VALID", {31'd0, OUT_VALID}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
